// File: rtl/tx_frame_sequencer.sv
// Transmit frame sequencer for one 802.11a-style OFDM frame.
// For each accepted sample strobe it produces the read address and source select
// for the next sample: short preamble, then long preamble, then N data symbols
// read from the IFFT buffer.
module tx_frame_sequencer #(
  parameter int NSYM_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 7,
  parameter int SHORT_LEN   = 160,
  parameter int LONG_CP_LEN = 32,
  parameter int FFT_LEN     = 64,
  parameter int CP_LEN      = 16
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  Start,
  input  logic [NSYM_WIDTH-1:0] in_Num_Symbols,
  input  logic                  in_tx_strobe,
  input  logic                  in_Sym_Ready,
  input  logic                  Abort,
  output logic                  Out_Strobe,
  output logic [1:0]            Out_Sel,
  output logic [ADDR_WIDTH-1:0] Rd_Addr,
  output logic                  Providing_Short,
  output logic                  Providing_Long,
  output logic                  Providing_Stream,
  output logic                  Sym_Release,
  output logic                  Underrun,
  output logic                  Frame_Done,
  output logic                  Busy
);

  localparam int KMAX = (SHORT_LEN > 2 * FFT_LEN) ? SHORT_LEN : 2 * FFT_LEN;
  localparam int KW   = $clog2(KMAX + 1);

  localparam logic [KW-1:0] SHORT_LAST   = KW'(SHORT_LEN - 1);
  localparam logic [KW-1:0] LONG_CP_LAST = KW'(LONG_CP_LEN - 1);
  localparam logic [KW-1:0] LONG_LAST    = KW'(2 * FFT_LEN - 1);
  localparam logic [KW-1:0] DATA_CP_LAST = KW'(CP_LEN - 1);
  localparam logic [KW-1:0] DATA_LAST    = KW'(FFT_LEN - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SHORT    = 3'd1;
  localparam logic [2:0] S_LONG_CP  = 3'd2;
  localparam logic [2:0] S_LONG     = 3'd3;
  localparam logic [2:0] S_WAIT_SYM = 3'd4;
  localparam logic [2:0] S_DATA_CP  = 3'd5;
  localparam logic [2:0] S_DATA     = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  logic [2:0]            state, state_n;
  logic [KW-1:0]         k, k_n, k_inc;
  logic [NSYM_WIDTH-1:0] rem, rem_n;

  logic                  emit;
  logic [1:0]            sel_c;
  logic [ADDR_WIDTH-1:0] addr_c;
  logic                  release_c;
  logic                  underrun_c;

  assign k_inc = k + 1'b1;

  // Next-state, counter and per-sample address decode; Abort overrides everything.
  always_comb begin
    state_n    = state;
    k_n        = k;
    rem_n      = rem;
    emit       = 1'b0;
    sel_c      = 2'd0;
    addr_c     = '0;
    release_c  = 1'b0;
    underrun_c = 1'b0;

    case (state)
      S_IDLE: begin
        if (Start) begin
          rem_n   = in_Num_Symbols;
          k_n     = '0;
          state_n = S_SHORT;
        end
      end
      S_SHORT: begin
        emit   = in_tx_strobe;
        sel_c  = 2'd0;
        addr_c = ADDR_WIDTH'(k[3:0]);
        if (in_tx_strobe) begin
          if (k == SHORT_LAST) begin
            k_n     = '0;
            state_n = S_LONG_CP;
          end else begin
            k_n = k_inc;
          end
        end
      end
      S_LONG_CP: begin
        emit   = in_tx_strobe;
        sel_c  = 2'd1;
        addr_c = ADDR_WIDTH'(FFT_LEN - LONG_CP_LEN) + ADDR_WIDTH'(k);
        if (in_tx_strobe) begin
          if (k == LONG_CP_LAST) begin
            k_n     = '0;
            state_n = S_LONG;
          end else begin
            k_n = k_inc;
          end
        end
      end
      S_LONG: begin
        emit   = in_tx_strobe;
        sel_c  = 2'd1;
        addr_c = ADDR_WIDTH'(k % FFT_LEN);
        if (in_tx_strobe) begin
          if (k == LONG_LAST) begin
            k_n     = '0;
            state_n = S_WAIT_SYM;
          end else begin
            k_n = k_inc;
          end
        end
      end
      S_WAIT_SYM: begin
        // Symbol availability is checked every cycle; a strobe only matters
        // when the buffer is empty, where it is dropped and flagged.
        if (rem == '0) begin
          state_n = S_DONE;
        end else if (in_Sym_Ready) begin
          k_n     = '0;
          state_n = S_DATA_CP;
        end else begin
          underrun_c = in_tx_strobe;
        end
      end
      S_DATA_CP: begin
        emit   = in_tx_strobe;
        sel_c  = 2'd2;
        addr_c = ADDR_WIDTH'(FFT_LEN - CP_LEN) + ADDR_WIDTH'(k);
        if (in_tx_strobe) begin
          if (k == DATA_CP_LAST) begin
            k_n     = '0;
            state_n = S_DATA;
          end else begin
            k_n = k_inc;
          end
        end
      end
      S_DATA: begin
        emit   = in_tx_strobe;
        sel_c  = 2'd2;
        addr_c = ADDR_WIDTH'(k);
        if (in_tx_strobe) begin
          if (k == DATA_LAST) begin
            release_c = 1'b1;
            k_n       = '0;
            state_n   = S_WAIT_SYM;
            if (rem != '0) begin
              rem_n = rem - 1'b1;
            end
          end else begin
            k_n = k_inc;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (Abort && (state != S_IDLE)) begin
      state_n    = S_IDLE;
      k_n        = '0;
      rem_n      = '0;
      emit       = 1'b0;
      release_c  = 1'b0;
      underrun_c = 1'b0;
    end
  end

  // Sequencer state, sample counter and remaining-symbol count.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= S_IDLE;
      k     <= '0;
      rem   <= '0;
    end else begin
      state <= state_n;
      k     <= k_n;
      rem   <= rem_n;
    end
  end

  // Registered outputs: sample fields appear one cycle after the accepted strobe;
  // Frame_Done and Busy track the state being entered so they align with it.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      Out_Strobe       <= 1'b0;
      Out_Sel          <= 2'd0;
      Rd_Addr          <= '0;
      Providing_Short  <= 1'b0;
      Providing_Long   <= 1'b0;
      Providing_Stream <= 1'b0;
      Sym_Release      <= 1'b0;
      Underrun         <= 1'b0;
      Frame_Done       <= 1'b0;
      Busy             <= 1'b0;
    end else begin
      Out_Strobe       <= emit;
      Out_Sel          <= emit ? sel_c : 2'd0;
      Rd_Addr          <= emit ? addr_c : '0;
      Providing_Short  <= emit && (state == S_SHORT);
      Providing_Long   <= emit && ((state == S_LONG_CP) || (state == S_LONG));
      Providing_Stream <= emit && ((state == S_DATA_CP) || (state == S_DATA));
      Sym_Release      <= release_c;
      Underrun         <= underrun_c;
      Frame_Done       <= (state_n == S_DONE);
      Busy             <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Scoreboard bench for tx_frame_sequencer: each Start pushes the whole expected
// sample list of the frame; a negedge monitor pops one entry per Out_Strobe.
module tb_tx_frame_sequencer;

  localparam int NW = 8;
  localparam int AW = 7;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b1;
  logic          Start = 1'b0;
  logic [NW-1:0] in_Num_Symbols = '0;
  logic          in_tx_strobe = 1'b0;
  logic          in_Sym_Ready = 1'b0;
  logic          Abort = 1'b0;
  logic          Out_Strobe;
  logic [1:0]    Out_Sel;
  logic [AW-1:0] Rd_Addr;
  logic          Providing_Short, Providing_Long, Providing_Stream;
  logic          Sym_Release, Underrun, Frame_Done, Busy;

  always #5 CLK = ~CLK;

  tx_frame_sequencer #(.NSYM_WIDTH(NW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST_n(RST_n), .Start(Start), .in_Num_Symbols(in_Num_Symbols),
    .in_tx_strobe(in_tx_strobe), .in_Sym_Ready(in_Sym_Ready), .Abort(Abort),
    .Out_Strobe(Out_Strobe), .Out_Sel(Out_Sel), .Rd_Addr(Rd_Addr),
    .Providing_Short(Providing_Short), .Providing_Long(Providing_Long),
    .Providing_Stream(Providing_Stream), .Sym_Release(Sym_Release),
    .Underrun(Underrun), .Frame_Done(Frame_Done), .Busy(Busy)
  );

  typedef struct packed {
    logic [1:0]    sel;
    logic [AW-1:0] addr;
    logic          sh;
    logic          lg;
    logic          st;
    logic          rel;
  } samp_t;

  samp_t  sbq[$];
  int     checks = 0;
  int     passes = 0;
  bit     frame_pending = 0;
  int     frame_len = 0;
  int     frame_samples = 0;
  int     underrun_cnt = 0;
  int     done_cnt = 0;
  longint cyc = 0;
  longint last_out = 0;
  bit     prev_strobe = 0;
  bit     busy_chk = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  // Reference frame: preamble then n symbols of cyclic prefix plus body.
  function automatic void push_frame(input int n);
    samp_t s;
    for (int i = 0; i < 160; i++) begin
      s = '0; s.sel = 2'd0; s.addr = AW'(i % 16); s.sh = 1'b1; sbq.push_back(s);
    end
    for (int i = 0; i < 32; i++) begin
      s = '0; s.sel = 2'd1; s.addr = AW'(32 + i); s.lg = 1'b1; sbq.push_back(s);
    end
    for (int i = 0; i < 128; i++) begin
      s = '0; s.sel = 2'd1; s.addr = AW'(i % 64); s.lg = 1'b1; sbq.push_back(s);
    end
    for (int m = 0; m < n; m++) begin
      for (int i = 0; i < 16; i++) begin
        s = '0; s.sel = 2'd2; s.addr = AW'(48 + i); s.st = 1'b1; sbq.push_back(s);
      end
      for (int i = 0; i < 64; i++) begin
        s = '0; s.sel = 2'd2; s.addr = AW'(i); s.st = 1'b1; s.rel = (i == 63);
        sbq.push_back(s);
      end
    end
    frame_len = 320 + 80 * n;
  endfunction

  // Monitor: pops and compares on every output sample, checks frame completion.
  always @(negedge CLK) begin : monitor
    samp_t e;
    samp_t a;
    cyc++;
    if (!RST_n) begin
      prev_strobe = 0;
      busy_chk    = 0;
    end else begin
      if (Out_Strobe) begin
        chk("strobe_latency", prev_strobe, 1);
        chk("sample_available", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          a = {Out_Sel, Rd_Addr, Providing_Short, Providing_Long, Providing_Stream, Sym_Release};
          chk($sformatf("sample[%0d]", frame_samples), a, e);
          chk("busy_during_sample", Busy, 1);
        end
        frame_samples++;
        last_out = cyc;
      end else begin
        chk("flags_without_strobe",
            {Providing_Short, Providing_Long, Providing_Stream, Sym_Release}, 0);
      end
      if (Underrun) underrun_cnt++;
      if (Frame_Done) begin
        chk("done_expected", frame_pending, 1);
        chk("done_queue_empty", sbq.size(), 0);
        chk("done_frame_len", frame_samples, frame_len);
        chk("done_latency", cyc - last_out, 1);
        frame_pending = 0;
        done_cnt++;
        busy_chk = 1;
      end else if (busy_chk) begin
        chk("busy_falls_after_done", Busy, 0);
        busy_chk = 0;
      end
      prev_strobe = in_tx_strobe && !Abort;
    end
  end

  task automatic step(input bit stb);
    @(posedge CLK); #1;
    Start = 1'b0;
    in_tx_strobe = stb;
  endtask

  task automatic begin_frame(input int n);
    push_frame(n);
    frame_pending = 1;
    frame_samples = 0;
    @(posedge CLK); #1;
    Start = 1'b1;
    in_Num_Symbols = NW'(n);
    in_tx_strobe = 1'b0;
  endtask

  // mode: 0 continuous strobes, >0 one strobe every 'mode' cycles, <0 random.
  // abort_at / rst_at: strobe count at which to abort or reset (-1 = never).
  task automatic drive_frame(input int n, input int mode, input int rdy_pct,
                             input int abort_at, input int rst_at);
    int issued;
    int t;
    int d0;
    bit stb;
    issued = 0;
    t = 0;
    d0 = done_cnt;
    begin_frame(n);
    forever begin
      @(posedge CLK); #1;
      Start = 1'b0;
      Abort = 1'b0;
      in_Num_Symbols = NW'($urandom);
      if (!frame_pending) break;
      if (t >= 20000) begin
        chk("frame_timeout", frame_pending, 0);
        sbq.delete();
        frame_pending = 0;
        break;
      end
      t++;
      if (mode == 0) stb = 1'b1;
      else if (mode > 0) stb = (t % mode) == 0;
      else stb = $urandom_range(0, 2) != 0;
      in_tx_strobe = stb;
      in_Sym_Ready = $urandom_range(0, 99) < rdy_pct;
      if ($urandom_range(0, 49) == 0) Start = 1'b1;
      if (stb && abort_at >= 0 && issued == abort_at) begin
        Abort = 1'b1;
        @(posedge CLK); #1;
        Abort = 1'b0;
        Start = 1'b0;
        in_tx_strobe = 1'b0;
        chk("abort_busy", Busy, 0);
        chk("abort_out_strobe", Out_Strobe, 0);
        chk("abort_flags", {Providing_Short, Providing_Long, Providing_Stream, Sym_Release}, 0);
        repeat (3) @(posedge CLK);
        #1;
        chk("abort_sample_count", frame_samples, abort_at);
        chk("abort_no_done", done_cnt, d0);
        sbq.delete();
        frame_pending = 0;
        break;
      end
      if (rst_at >= 0 && issued == rst_at) begin
        Start = 1'b0;
        chk("pre_reset_busy", Busy, 1);
        chk("pre_reset_stream", Providing_Stream, 1);
        #2;
        RST_n = 1'b0;
        #1;
        chk("async_reset_busy", Busy, 0);
        chk("async_reset_outputs",
            {Out_Strobe, Out_Sel, Rd_Addr, Providing_Short, Providing_Long,
             Providing_Stream, Sym_Release, Underrun, Frame_Done}, 0);
        in_tx_strobe = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        sbq.delete();
        frame_pending = 0;
        RST_n = 1'b1;
        chk("reset_no_done", done_cnt, d0);
        break;
      end
      issued += int'(stb);
    end
    Start = 1'b0;
    Abort = 1'b0;
    in_tx_strobe = 1'b0;
    in_Sym_Ready = 1'b0;
  endtask

  task automatic underrun_test();
    int u0;
    int t;
    begin_frame(1);
    in_Sym_Ready = 1'b0;
    repeat (320) step(1);
    repeat (2) step(0);
    chk("preamble_before_wait", frame_samples, 320);
    u0 = underrun_cnt;
    repeat (5) step(1);
    repeat (2) step(0);
    chk("underrun_pulses", underrun_cnt - u0, 5);
    chk("no_output_while_starved", frame_samples, 320);
    in_Sym_Ready = 1'b1;
    repeat (2) step(0);
    t = 0;
    while (frame_pending && t < 2000) begin
      step(1);
      t++;
    end
    chk("underrun_frame_done", frame_pending, 0);
    chk("no_extra_underrun", underrun_cnt - u0, 5);
    step(0);
    in_Sym_Ready = 1'b0;
  endtask

  initial begin
    #1 RST_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_strobe", Out_Strobe, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_frame_done", Frame_Done, 0);
    chk("rst_addr_sel", {Out_Sel, Rd_Addr}, 0);
    chk("rst_pulses", {Sym_Release, Underrun}, 0);
    chk("rst_providing", {Providing_Short, Providing_Long, Providing_Stream}, 0);
    RST_n = 1'b1;
    repeat (2) step(0);

    drive_frame(2, 0, 100, -1, -1);
    drive_frame(0, 0, 100, -1, -1);
    drive_frame(1, 4, 100, -1, -1);
    underrun_test();
    drive_frame(3, 0, 100, 200, -1);
    drive_frame(1, -1, 70, -1, -1);
    drive_frame(2, 0, 100, -1, 360);
    for (int i = 0; i < 4; i++) begin
      drive_frame(int'($urandom_range(0, 3)), -1, 60, -1, -1);
    end
    repeat (4) step(0);
    chk("total_frames_done", done_cnt, 9);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
